// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: sequences a byte-serial ChaCha20 core into a keystream source (key/counter/nonce byte file).
// Latency: 1 clear + 64 load + core compute + 64 drain cycles per block; 1 byte/clk while ks_ready stays high.
// Backpressure: ks_ready low stalls core reads; the last byte of a block is held until accepted.
module chacha_stream_ctrl #(
  parameter bit ALLOW_WRAP = 1'b0,
  parameter int TIMEOUT    = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [5:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  output logic       ks_valid,
  output logic [7:0] ks_data,
  input  logic       ks_ready,
  output logic       err_wrap,
  output logic       err_timeout,
  output logic       blk_rst_n,
  output logic       blk_write,
  output logic [7:0] blk_data_in,
  output logic       blk_read,
  input  logic       blk_ready,
  input  logic [7:0] blk_data_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]    state;
  logic [7:0]    regf [48];
  logic [5:0]    load_idx;
  logic [5:0]    rd_cnt;
  logic [TW-1:0] wait_cnt;
  logic          stop_clr;
  logic [7:0]    load_byte;
  logic [31:0]   ctr;
  logic [31:0]   ctr_nxt;

  // Bytes 0..15 of every block: "expand 32-byte k", byte 0 first.
  function automatic logic [7:0] const_byte(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h65;
      4'd1:    return 8'h78;
      4'd2:    return 8'h70;
      4'd3:    return 8'h61;
      4'd4:    return 8'h6e;
      4'd5:    return 8'h64;
      4'd6:    return 8'h20;
      4'd7:    return 8'h33;
      4'd8:    return 8'h32;
      4'd9:    return 8'h2d;
      4'd10:   return 8'h62;
      4'd11:   return 8'h79;
      4'd12:   return 8'h74;
      4'd13:   return 8'h65;
      4'd14:   return 8'h20;
      default: return 8'h6b;
    endcase
  endfunction

  // Block counter lives in state bytes 48..51 (regfile 32..35), little-endian.
  assign ctr     = {regf[35], regf[34], regf[33], regf[32]};
  assign ctr_nxt = ctr + 32'd1;

  always_comb begin
    load_byte = const_byte(load_idx[3:0]);
    if (load_idx >= 6'd16) load_byte = regf[load_idx - 6'd16];
  end

  assign busy        = !rst && (state != S_IDLE) && (state != S_ERR);
  assign blk_rst_n   = ~(rst | (state == S_CLEAR) | stop_clr);
  assign blk_write   = !rst && (state == S_LOAD);
  assign blk_data_in = blk_write ? load_byte : 8'h00;
  assign blk_read    = !rst && (state == S_DRAIN) && (!ks_valid || ks_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      load_idx    <= '0;
      rd_cnt      <= '0;
      wait_cnt    <= '0;
      stop_clr    <= 1'b0;
      ks_valid    <= 1'b0;
      ks_data     <= 8'h00;
      err_wrap    <= 1'b0;
      err_timeout <= 1'b0;
      for (int i = 0; i < 48; i++) regf[i] <= 8'h00;
    end else begin
      stop_clr <= 1'b0;

      if (cfg_we && !busy && (cfg_addr >= 6'd16)) regf[cfg_addr - 6'd16] <= cfg_wdata;

      if (ks_valid && ks_ready) ks_valid <= 1'b0;
      if (blk_read) begin
        ks_valid <= 1'b1;
        ks_data  <= blk_data_out;
      end

      if (stop) begin
        state    <= S_IDLE;
        ks_valid <= 1'b0;
        stop_clr <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (start) begin
              state       <= S_CLEAR;
              err_wrap    <= 1'b0;
              err_timeout <= 1'b0;
            end
          end
          S_CLEAR: begin
            state    <= S_LOAD;
            load_idx <= '0;
          end
          S_LOAD: begin
            load_idx <= load_idx + 6'd1;
            if (load_idx == 6'd63) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end
          end
          S_WAIT: begin
            if (blk_ready) begin
              state  <= S_DRAIN;
              rd_cnt <= '0;
            end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
              state       <= S_ERR;
              err_timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_DRAIN: begin
            if (blk_read) begin
              rd_cnt <= rd_cnt + 6'd1;
              if (rd_cnt == 6'd63) state <= S_NEXT;
            end
          end
          S_NEXT: begin
            regf[32] <= ctr_nxt[7:0];
            regf[33] <= ctr_nxt[15:8];
            regf[34] <= ctr_nxt[23:16];
            regf[35] <= ctr_nxt[31:24];
            if ((ctr == 32'hFFFF_FFFF) && !ALLOW_WRAP) begin
              state    <= S_ERR;
              err_wrap <= 1'b1;
            end else begin
              state <= S_CLEAR;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl: behavioural ChaCha20 core, a stream sink with scripted ready
// patterns, and directed sessions (RFC vector, backpressure, stop/restart, wrap, timeout).
module tb_chacha_stream_ctrl;

  localparam int TIMEOUT  = 63;
  localparam int CORE_LAT = 29;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cfg_we, start, stop, ks_ready, blk_ready;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_wdata, blk_data_out;
  logic       busy, ks_valid, err_wrap, err_timeout, blk_rst_n, blk_write, blk_read;
  logic [7:0] ks_data, blk_data_in;
  logic       w_busy, w_ks_valid, w_err_wrap, w_err_timeout, w_blk_rst_n, w_blk_write, w_blk_read;
  logic [7:0] w_ks_data, w_blk_data_in;

  chacha_stream_ctrl #(.ALLOW_WRAP(1'b0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .stop(stop), .busy(busy), .ks_valid(ks_valid), .ks_data(ks_data),
    .ks_ready(ks_ready), .err_wrap(err_wrap), .err_timeout(err_timeout),
    .blk_rst_n(blk_rst_n), .blk_write(blk_write), .blk_data_in(blk_data_in),
    .blk_read(blk_read), .blk_ready(blk_ready), .blk_data_out(blk_data_out)
  );

  // Wrapping variant runs in lockstep; only its load bytes and busy are observed.
  chacha_stream_ctrl #(.ALLOW_WRAP(1'b1), .TIMEOUT(TIMEOUT)) dut_wrap (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .stop(stop), .busy(w_busy), .ks_valid(w_ks_valid), .ks_data(w_ks_data),
    .ks_ready(ks_ready), .err_wrap(w_err_wrap), .err_timeout(w_err_timeout),
    .blk_rst_n(w_blk_rst_n), .blk_write(w_blk_write), .blk_data_in(w_blk_data_in),
    .blk_read(w_blk_read), .blk_ready(blk_ready), .blk_data_out(blk_data_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha_block(input logic [511:0] st);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] res;
    int a, b, c, d, j;
    for (int i = 0; i < 16; i++) begin
      s[i] = st[32*i +: 32];
      x[i] = s[i];
    end
    for (int r = 0; r < 10; r++) begin
      for (int q = 0; q < 8; q++) begin
        if (q < 4) begin
          a = q; b = 4 + q; c = 8 + q; d = 12 + q;
        end else begin
          j = q - 4;
          a = j; b = 4 + ((j + 1) % 4); c = 8 + ((j + 2) % 4); d = 12 + ((j + 3) % 4);
        end
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
    return res;
  endfunction

  function automatic logic [511:0] with_ctr(input logic [511:0] im, input logic [31:0] c);
    im[384 +: 32] = c;
    return im;
  endfunction

  // Behavioural core: write pointer and read pointer both reset by blk_rst_n.
  logic [511:0] core_in  = '0;
  logic [511:0] core_out = '0;
  logic [5:0]   raddr    = '0;
  int           wcnt     = 0;
  int           rcnt     = 0;
  int           cd       = 0;
  logic         ready_en = 1'b1;
  int           reads_log [$];

  always @(posedge clk) begin
    if (!blk_rst_n) begin
      if (rcnt != 0) reads_log.push_back(rcnt);
      wcnt <= 0; rcnt <= 0; cd <= 0; raddr <= '0; blk_ready <= 1'b0;
    end else begin
      if (blk_write) begin
        if (wcnt < 64) core_in[8*wcnt +: 8] <= blk_data_in;
        if (wcnt == 63) cd <= CORE_LAT;
        wcnt <= wcnt + 1;
      end
      if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          core_out  <= chacha_block(core_in);
          blk_ready <= ready_en;
        end
      end
      if (blk_read) begin
        raddr <= raddr + 6'd1;
        rcnt  <= rcnt + 1;
      end
    end
  end
  assign blk_data_out = core_out[8*raddr +: 8];

  logic [511:0] w_load = '0;
  int           w_wcnt = 0;
  always @(posedge clk) begin
    if (!w_blk_rst_n) w_wcnt <= 0;
    else if (w_blk_write) begin
      if (w_wcnt < 64) w_load[8*w_wcnt +: 8] <= w_blk_data_in;
      w_wcnt <= w_wcnt + 1;
    end
  end

  // Sink: block 0 free-running, block 1 toggling ready, block 2 held off 20 valid cycles.
  logic [7:0] rx [$];
  int         hold_cnt = 0;
  logic       tog = 1'b0;
  always @(negedge clk) begin
    int bi;
    bi  = rx.size() / 64;
    tog = ~tog;
    if (bi == 1) ks_ready = tog;
    else if (bi == 2) begin
      ks_ready = (hold_cnt >= 20);
      if (ks_valid && hold_cnt < 20) hold_cnt++;
    end else ks_ready = 1'b1;
    if (ks_valid && ks_ready) rx.push_back(ks_data);
  end

  logic [511:0] img;

  task automatic write_cfg(input int addr, input logic [7:0] val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr[5:0]; cfg_wdata = val;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_counter(input logic [31:0] c);
    for (int i = 0; i < 4; i++) write_cfg(48 + i, c[8*i +: 8]);
    img = with_ctr(img, c);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int t = 0;
    while (rx.size() < n && t < 3000) begin @(negedge clk); t++; end
    check_eq(tag, 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic check_block(input int base, input logic [31:0] c, input string tag);
    logic [511:0] ks;
    int bad = 0;
    ks = chacha_block(with_ctr(img, c));
    for (int k = 0; k < 64; k++)
      if (rx.size() <= base + k || rx[base + k] !== ks[8*k +: 8]) bad++;
    check_eq(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] cs;
    logic [127:0] rfc;
    logic [95:0]  nonce;
    int t, n;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; stop = 1'b0;
    cs    = "expand 32-byte k";
    rfc   = 128'h10f1e7e4d13b5915500fdd1fa32071c4;
    nonce = 96'h000000090000004a00000000;
    img   = '0;
    for (int i = 0; i < 16; i++) img[8*i +: 8] = cs[127 - 8*i -: 8];

    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ks_valid", ks_valid, 0);
    check_eq("rst_ks_data", ks_data, 0);
    check_eq("rst_err_wrap", err_wrap, 0);
    check_eq("rst_err_timeout", err_timeout, 0);
    check_eq("rst_blk_rst_n", blk_rst_n, 0);
    check_eq("rst_blk_write", blk_write, 0);
    check_eq("rst_blk_read", blk_read, 0);
    check_eq("rst_blk_data_in", blk_data_in, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_blk_rst_n", blk_rst_n, 1);

    // RFC 8439 2.3.2 configuration; the write to constant byte 5 must not stick.
    write_cfg(5, 8'hAA);
    for (int i = 0; i < 32; i++) begin
      write_cfg(16 + i, 8'(i));
      img[8*(16 + i) +: 8] = 8'(i);
    end
    set_counter(32'd1);
    for (int i = 0; i < 12; i++) begin
      write_cfg(52 + i, nonce[95 - 8*i -: 8]);
      img[8*(52 + i) +: 8] = nonce[95 - 8*i -: 8];
    end

    rx.delete(); reads_log.delete(); hold_cnt = 0;
    pulse_start();
    check_eq("start_busy", busy, 1);
    wait_rx(192, "rx_three_blocks");
    for (int k = 0; k < 16; k++) check_eq($sformatf("rfc_byte%0d", k), rx[k], rfc[127 - 8*k -: 8]);
    check_block(0,   32'd1, "blk1_free_running");
    check_block(64,  32'd2, "blk2_toggle_ready");
    check_block(128, 32'd3, "blk3_hold_ready");

    // Stop part-way through loading block 4.
    t = 0;
    while (wcnt != 30 && t < 500) begin @(negedge clk); t++; end
    check_eq("reach_load_byte30", wcnt, 30);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("stop_clear_pulse", blk_rst_n, 0);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_ks_valid", ks_valid, 0);
    @(negedge clk);
    check_eq("stop_clear_done", blk_rst_n, 1);
    check_eq("reads_blocks", reads_log.size(), 3);
    for (int b = 0; b < reads_log.size(); b++) check_eq($sformatf("reads_blk%0d", b), reads_log[b], 64);
    check_eq("const_bytes_lo", core_in[31:0], img[31:0]);
    check_eq("const_byte5", core_in[47:40], 8'h64);

    // Restart resumes at the advanced counter and matches an uninterrupted block 4.
    rx.delete(); hold_cnt = 0;
    pulse_start();
    wait_rx(64, "rx_restart");
    check_eq("restart_ctr_loaded", core_in[384 +: 32], 32'd4);
    check_block(0, 32'd4, "blk4_after_stop");
    pulse_stop();

    // Counter wrap: error without ALLOW_WRAP, silent wrap with it. Config writes while busy drop.
    set_counter(32'hFFFF_FFFF);
    rx.delete(); hold_cnt = 0;
    pulse_start();
    wait_rx(1, "rx_wrap_first");
    write_cfg(20, 8'h55);
    wait_rx(64, "rx_wrap_block");
    t = 0;
    while (busy && t < 20) begin @(negedge clk); t++; end
    check_eq("wrap_busy", busy, 0);
    check_eq("wrap_err_wrap", err_wrap, 1);
    check_eq("wrap_err_timeout", err_timeout, 0);
    check_block(0, 32'hFFFF_FFFF, "blk_ctr_ffffffff");
    repeat (2) @(negedge clk);
    t = 0;
    while (w_wcnt < 64 && t < 300) begin @(negedge clk); t++; end
    check_eq("allow_wrap_ctr", w_load[384 +: 32], 32'd0);
    check_eq("allow_wrap_busy", w_busy, 1);
    pulse_start();
    check_eq("err_start_clears_wrap", err_wrap, 0);
    check_eq("err_start_busy", busy, 1);
    pulse_stop();
    check_eq("wrap_variant_stopped", w_busy, 0);

    // Core never ready: timeout counted from the first WAIT cycle.
    set_counter(32'd7);
    ready_en = 1'b0;
    rx.delete(); hold_cnt = 0;
    pulse_start();
    t = 0;
    while (wcnt != 64 && t < 200) begin @(negedge clk); t++; end
    check_eq("timeout_load_done", wcnt, 64);
    n = 0;
    while (!err_timeout && n < 200) begin @(negedge clk); n++; end
    check_eq("timeout_cycles", n, TIMEOUT);
    check_eq("timeout_busy", busy, 0);
    check_eq("timeout_no_extra_writes", wcnt, 64);
    check_eq("drain_cfg_dropped", core_in[8*20 +: 8], 8'h04);
    ready_en = 1'b1;
    pulse_start();
    check_eq("timeout_cleared", err_timeout, 0);
    check_eq("timeout_restart_busy", busy, 1);
    wait_rx(64, "rx_after_timeout");
    check_block(0, 32'd7, "blk_ctr7_after_timeout");
    pulse_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
